// File: rtl/scm_stream_pkg.sv
// Shared types and constants for the SCM burst read initiator.
package scm_stream_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } stream_state_e;

    localparam int BUF_DEPTH = 2;
    localparam int BUF_CNT_W = $clog2(BUF_DEPTH + 1);

endpackage

// File: rtl/scm_stream_skid_fifo.sv
// Two-entry FIFO that holds read words (plus last flag) between memory and consumer.
module scm_stream_skid_fifo
    import scm_stream_pkg::*;
#(
    parameter int WIDTH = 33
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic [WIDTH-1:0]     push_data,
    input  logic                 pop,
    output logic [BUF_CNT_W-1:0] count,
    output logic [WIDTH-1:0]     head
);

    logic [WIDTH-1:0] entry [BUF_DEPTH];
    logic             wr_ptr;
    logic             rd_ptr;

    // Writing the slot being popped in the same cycle is safe: the pop reads the old value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                entry[i] <= '0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= '0;
        end else begin
            if (push) begin
                entry[wr_ptr] <= push_data;
                wr_ptr        <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + BUF_CNT_W'(1);
                2'b01:   count <= count - BUF_CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign head = entry[rd_ptr];

endmodule

// File: rtl/scm_stream_reader.sv
// Burst read initiator for 1R1W SCM register files: issues reads with credit-based
// flow control and returns the words on a valid/ready stream.
module scm_stream_reader
    import scm_stream_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [ADDR_WIDTH-1:0] cmd_base_i,
    input  logic [LEN_WIDTH-1:0]  cmd_len_i,
    output logic                  rd_en_o,
    output logic [ADDR_WIDTH-1:0] rd_addr_o,
    input  logic [DATA_WIDTH-1:0] rd_data_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic                  out_last_o,
    output logic                  done_o,
    output logic                  busy_o
);

    localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(2 ** ADDR_WIDTH);
    localparam logic [LEN_WIDTH-1:0] ONE     = LEN_WIDTH'(1);

    stream_state_e         state_q;
    stream_state_e         state_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LEN_WIDTH-1:0]  issue_cnt_q;
    logic [LEN_WIDTH-1:0]  out_cnt_q;
    logic                  inflight_q;
    logic                  inflight_last_q;
    logic                  done_q;

    logic                  accept;
    logic                  pop;
    logic                  credit;
    logic                  issue_last;
    logic [2:0]            occupancy;
    logic [BUF_CNT_W-1:0]  buf_count;
    logic [DATA_WIDTH:0]   buf_head;

    assign accept     = cmd_valid_i & cmd_ready_o;
    assign pop        = out_valid_o & out_ready_i;
    assign issue_last = (issue_cnt_q == ONE);

    // A read may only issue if its data is guaranteed a FIFO slot when it returns.
    assign occupancy = 3'(buf_count) + 3'(inflight_q) - 3'(pop);
    assign credit    = (occupancy < 3'd2);

    assign rd_en_o     = (state_q == STREAM) && (issue_cnt_q != '0) && credit;
    assign rd_addr_o   = addr_q;
    assign cmd_ready_o = (state_q == IDLE);
    assign busy_o      = (state_q != IDLE);
    assign done_o      = done_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept && (cmd_len_i != '0)) begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (rd_en_o && issue_last) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && (out_cnt_q == ONE)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The last flag travels with the read so the FIFO head always knows if it ends the burst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q          <= '0;
            issue_cnt_q     <= '0;
            out_cnt_q       <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            if (accept) begin
                addr_q      <= cmd_base_i;
                issue_cnt_q <= cmd_len_i;
                out_cnt_q   <= cmd_len_i;
            end else begin
                if (rd_en_o) begin
                    addr_q      <= addr_q + ADDR_WIDTH'(1);
                    issue_cnt_q <= issue_cnt_q - ONE;
                end
                if (pop) begin
                    out_cnt_q <= out_cnt_q - ONE;
                end
            end
            inflight_q      <= rd_en_o;
            inflight_last_q <= rd_en_o && issue_last;
            done_q          <= (accept && (cmd_len_i == '0)) ||
                               ((state_q == DRAIN) && pop && (out_cnt_q == ONE));
        end
    end

    scm_stream_skid_fifo #(
        .WIDTH (DATA_WIDTH + 1)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight_q),
        .push_data ({inflight_last_q, rd_data_i}),
        .pop       (pop),
        .count     (buf_count),
        .head      (buf_head)
    );

    assign out_valid_o = (buf_count != '0);
    assign out_data_o  = buf_head[DATA_WIDTH-1:0];
    assign out_last_o  = out_valid_o & buf_head[DATA_WIDTH];

`ifndef SYNTHESIS
    len_legal_a: assert property (@(posedge clk) disable iff (rst)
        accept |-> (cmd_len_i <= MAX_LEN));

    no_overflow_a: assert property (@(posedge clk) disable iff (rst)
        inflight_q |-> ((buf_count < BUF_CNT_W'(BUF_DEPTH)) || pop));
`endif

endmodule
